// File: rtl/wb_master_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin grant held for a whole cycle
// and a per-transfer watchdog that terminates stalled strobes.
module wb_master_arbiter #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_data_w,
    input  logic                  m0_wr,
    input  logic                  m0_strobe,
    input  logic                  m0_cycle,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_data_r,

    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_data_w,
    input  logic                  m1_wr,
    input  logic                  m1_strobe,
    input  logic                  m1_cycle,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_data_r,

    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_data_w,
    output logic                  s_wr,
    output logic                  s_strobe,
    output logic                  s_cycle,
    input  logic                  s_ack,
    input  logic [DATA_WIDTH-1:0] s_data_r,

    output logic [1:0]            grant,
    output logic                  timeout_flag,
    input  logic                  timeout_clr
);

    localparam bit          WdEn = (TIMEOUT > 0);
    localparam int unsigned WdW  = WdEn ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WdW-1:0] WdLast = WdEn ? WdW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        StIdle,
        StGrant0,
        StGrant1
    } state_e;

    state_e         state_q;
    logic           last_grant_q;
    logic [WdW-1:0] wd_cnt_q;
    logic           timeout_flag_q;

    logic                  granted;
    logic                  own0;
    logic                  own1;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data_w;
    logic                  sel_wr;
    logic                  sel_strobe;
    logic                  sel_cycle;
    logic                  wd_fire;

    always_comb begin
        own0       = (state_q == StGrant0);
        own1       = (state_q == StGrant1);
        granted    = own0 | own1;
        sel_addr   = own1 ? m1_addr   : m0_addr;
        sel_data_w = own1 ? m1_data_w : m0_data_w;
        sel_wr     = own1 ? m1_wr     : m0_wr;
        sel_strobe = own1 ? m1_strobe : m0_strobe;
        sel_cycle  = own1 ? m1_cycle  : m0_cycle;
        // A real ack in the firing cycle wins, so the watchdog only fires without one.
        wd_fire    = WdEn && granted && sel_strobe && !s_ack && (wd_cnt_q == WdLast);
    end

    always_comb begin
        s_addr       = granted ? sel_addr   : '0;
        s_data_w     = granted ? sel_data_w : '0;
        s_wr         = granted & sel_wr;
        s_strobe     = granted & sel_strobe & ~wd_fire;
        s_cycle      = granted & sel_cycle  & ~wd_fire;
        m0_ack       = own0 & (s_ack | wd_fire);
        m1_ack       = own1 & (s_ack | wd_fire);
        m0_data_r    = (own0 && wd_fire) ? '0 : s_data_r;
        m1_data_r    = (own1 && wd_fire) ? '0 : s_data_r;
        grant        = {own1, own0};
        timeout_flag = timeout_flag_q;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q        <= StIdle;
            last_grant_q   <= 1'b1;
            wd_cnt_q       <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    wd_cnt_q <= '0;
                    // On contention the master that did not own the bus last goes first.
                    if (m0_cycle && (!m1_cycle || last_grant_q)) begin
                        state_q      <= StGrant0;
                        last_grant_q <= 1'b0;
                    end else if (m1_cycle) begin
                        state_q      <= StGrant1;
                        last_grant_q <= 1'b1;
                    end
                end
                StGrant0, StGrant1: begin
                    if (wd_fire || !sel_cycle) begin
                        state_q <= StIdle;
                    end
                    if (WdEn && sel_strobe && !s_ack && !wd_fire) begin
                        wd_cnt_q <= wd_cnt_q + WdW'(1);
                    end else begin
                        wd_cnt_q <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (wd_fire) begin
                timeout_flag_q <= 1'b1;
            end else if (timeout_clr) begin
                timeout_flag_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: ack scoreboard plus immediate-assertion checks.
module tb_wb_master_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [14:0] m0_addr, m1_addr, s_addr;
    logic [15:0] m0_data_w, m1_data_w, m0_data_r, m1_data_r, s_data_w, s_data_r;
    logic        m0_wr, m0_strobe, m0_cycle, m0_ack;
    logic        m1_wr, m1_strobe, m1_cycle, m1_ack;
    logic        s_wr, s_strobe, s_cycle, s_ack;
    logic [1:0]  grant;
    logic        timeout_flag, timeout_clr;

    typedef struct packed {
        logic        mst;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wb_master_arbiter #(
        .ADDR_WIDTH(15),
        .DATA_WIDTH(16),
        .TIMEOUT   (8)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .m0_addr     (m0_addr),
        .m0_data_w   (m0_data_w),
        .m0_wr       (m0_wr),
        .m0_strobe   (m0_strobe),
        .m0_cycle    (m0_cycle),
        .m0_ack      (m0_ack),
        .m0_data_r   (m0_data_r),
        .m1_addr     (m1_addr),
        .m1_data_w   (m1_data_w),
        .m1_wr       (m1_wr),
        .m1_strobe   (m1_strobe),
        .m1_cycle    (m1_cycle),
        .m1_ack      (m1_ack),
        .m1_data_r   (m1_data_r),
        .s_addr      (s_addr),
        .s_data_w    (s_data_w),
        .s_wr        (s_wr),
        .s_strobe    (s_strobe),
        .s_cycle     (s_cycle),
        .s_ack       (s_ack),
        .s_data_r    (s_data_r),
        .grant       (grant),
        .timeout_flag(timeout_flag),
        .timeout_clr (timeout_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push(input logic mst, input logic [15:0] data);
        exp_t e;
        e.mst  = mst;
        e.data = data;
        sb.push_back(e);
    endtask

    // Every ack a master sees must match the next expected transfer completion.
    always @(negedge clk) begin
        if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_master", {30'd0, m1_ack, m0_ack}, mon_e.mst ? 32'd2 : 32'd1);
                chk("ack_data", mon_e.mst ? m1_data_r : m0_data_r, mon_e.data);
            end
        end
    end

    initial begin
        resetn = 1'b1;
        m0_addr = '0; m0_data_w = '0; m0_wr = 0; m0_strobe = 0; m0_cycle = 0;
        m1_addr = '0; m1_data_w = '0; m1_wr = 0; m1_strobe = 0; m1_cycle = 0;
        s_ack = 0; s_data_r = '0; timeout_clr = 0;

        repeat (2) edge_();
        resetn = 1'b0;
        mid();
        chk("rst_grant", grant, 0);
        chk("rst_s_cycle", s_cycle, 0);
        chk("rst_s_strobe", s_strobe, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_flag", timeout_flag, 0);
        chk("rst_acks", {m1_ack, m0_ack}, 0);

        // Single m0 read, slave acks on the third granted cycle.
        edge_(); m0_cycle = 1; m0_strobe = 1; m0_addr = 15'h0010; m0_wr = 0;
        mid(); chk("t1_pre_grant", grant, 0);
        edge_(); mid();
        chk("t1_grant", grant, 1);
        chk("t1_s_addr", s_addr, 15'h0010);
        chk("t1_s_strobe", s_strobe, 1);
        chk("t1_s_cycle", s_cycle, 1);
        edge_();
        edge_(); s_ack = 1; s_data_r = 16'hA5A5; push(0, 16'hA5A5);
        mid(); chk("t1_m1_ack", m1_ack, 0);
        edge_(); s_ack = 0; m0_cycle = 0; m0_strobe = 0;
        mid(); chk("t1_hold", grant, 1);
        edge_(); mid(); chk("t1_release", grant, 0);

        edge_(); resetn = 1;
        edge_(); resetn = 0;

        // Contention right after reset: m0 first, then m1.
        edge_();
        m0_cycle = 1; m0_strobe = 1; m0_wr = 1; m0_addr = 15'h0100; m0_data_w = 16'h1111;
        m1_cycle = 1; m1_strobe = 1; m1_wr = 1; m1_addr = 15'h0200; m1_data_w = 16'h2222;
        edge_(); s_ack = 1; s_data_r = 16'h0BEE; push(0, 16'h0BEE);
        mid();
        chk("t2_grant0", grant, 1);
        chk("t2_s_addr0", s_addr, 15'h0100);
        chk("t2_s_data_w0", s_data_w, 16'h1111);
        chk("t2_s_wr0", s_wr, 1);
        edge_(); s_ack = 0; m0_cycle = 0; m0_strobe = 0; m0_wr = 0;
        mid(); chk("t2_hold0", grant, 1);
        edge_(); mid(); chk("t2_gap", grant, 0);
        edge_(); s_ack = 1; s_data_r = 16'h0C0C; push(1, 16'h0C0C);
        mid();
        chk("t2_grant1", grant, 2);
        chk("t2_s_addr1", s_addr, 15'h0200);
        chk("t2_s_data_w1", s_data_w, 16'h2222);
        edge_(); s_ack = 0; m1_cycle = 0; m1_strobe = 0; m1_wr = 0;
        edge_(); mid(); chk("t2_idle", grant, 0);

        // Solo m0 transfer, then contention must favour m1.
        edge_(); m0_cycle = 1; m0_strobe = 1; m0_addr = 15'h0101;
        edge_(); s_ack = 1; s_data_r = 16'h1234; push(0, 16'h1234);
        mid(); chk("t2b_solo", grant, 1);
        edge_(); s_ack = 0; m0_cycle = 0; m0_strobe = 0;
        edge_();
        m0_cycle = 1; m0_strobe = 1; m0_addr = 15'h0102;
        m1_cycle = 1; m1_strobe = 1; m1_addr = 15'h0202;
        edge_(); s_ack = 1; s_data_r = 16'h2020; push(1, 16'h2020);
        mid(); chk("t2b_m1_first", grant, 2);
        edge_(); s_ack = 0; m1_cycle = 0; m1_strobe = 0;
        mid(); chk("t2b_hold1", grant, 2);
        edge_(); mid(); chk("t2b_gap", grant, 0);
        edge_(); s_ack = 1; s_data_r = 16'h3030; push(0, 16'h3030);
        mid();
        chk("t2b_m0_second", grant, 1);
        chk("t2b_s_addr", s_addr, 15'h0102);
        edge_(); s_ack = 0; m0_cycle = 0; m0_strobe = 0;
        edge_();

        // m1 holds cycle over four writes while m0 waits.
        edge_(); m1_cycle = 1; m1_strobe = 1; m1_wr = 1; m1_addr = 15'h0020; m1_data_w = 16'h4000;
        for (int k = 0; k < 4; k++) begin
            edge_();
            m1_addr = 15'h0020 + 15'(k);
            m1_data_w = 16'h4000 + 16'(k);
            s_ack = 1; s_data_r = 16'h0100 + 16'(k);
            push(1, 16'h0100 + 16'(k));
            if (k == 0) begin
                m0_cycle = 1; m0_strobe = 1; m0_addr = 15'h0050;
            end
            mid();
            chk("t3_grant", grant, 2);
            chk("t3_s_addr", s_addr, 32'h20 + 32'(k));
        end
        edge_(); s_ack = 0; m1_cycle = 0; m1_strobe = 0; m1_wr = 0;
        mid(); chk("t3_no_preempt", grant, 2);
        edge_(); mid(); chk("t3_gap", grant, 0);
        edge_(); s_ack = 1; s_data_r = 16'h5555; push(0, 16'h5555);
        mid();
        chk("t3_m0_grant", grant, 1);
        chk("t3_m0_addr", s_addr, 15'h0050);
        edge_(); s_ack = 0; m0_cycle = 0; m0_strobe = 0;
        edge_();

        // Slave never acks: watchdog fires on the 8th stalled cycle.
        edge_(); m0_cycle = 1; m0_strobe = 1; m0_addr = 15'h0030; s_data_r = 16'hDEAD;
        for (int k = 1; k <= 8; k++) begin
            edge_();
            if (k == 8) push(0, 16'h0000);
            mid();
            chk("t4_grant", grant, 1);
            chk("t4_s_strobe", s_strobe, (k < 8) ? 32'd1 : 32'd0);
            chk("t4_s_cycle", s_cycle, (k < 8) ? 32'd1 : 32'd0);
            chk("t4_flag_pre", timeout_flag, 0);
        end
        edge_(); m0_cycle = 0; m0_strobe = 0;
        mid();
        chk("t4_idle", grant, 0);
        chk("t4_flag", timeout_flag, 1);
        edge_(); edge_(); mid(); chk("t4_sticky", timeout_flag, 1);
        edge_(); timeout_clr = 1;
        mid(); chk("t4_clr_pending", timeout_flag, 1);
        edge_(); timeout_clr = 0;
        mid(); chk("t4_cleared", timeout_flag, 0);

        // Real ack on exactly the 8th stalled cycle wins over the watchdog.
        edge_(); m0_cycle = 1; m0_strobe = 1; m0_addr = 15'h0031;
        for (int k = 1; k <= 8; k++) begin
            edge_();
            if (k == 8) begin
                s_ack = 1; s_data_r = 16'h5A5A; push(0, 16'h5A5A);
            end
            mid();
            chk("t5_s_strobe", s_strobe, 1);
        end
        edge_(); s_ack = 0; m0_cycle = 0; m0_strobe = 0;
        mid();
        chk("t5_flag", timeout_flag, 0);
        chk("t5_still_owned", grant, 1);
        edge_(); mid();
        chk("t5_idle", grant, 0);
        chk("t5_flag_after", timeout_flag, 0);

        // Reset while m1 owns the bus mid-write.
        edge_(); m1_cycle = 1; m1_strobe = 1; m1_wr = 1; m1_addr = 15'h0040; m1_data_w = 16'h7777;
        edge_(); mid();
        chk("t6_grant1", grant, 2);
        chk("t6_s_cycle", s_cycle, 1);
        edge_(); resetn = 1;
        mid(); chk("t6_pre_reset", grant, 2);
        edge_(); s_ack = 1;
        mid();
        chk("t6_grant_rst", grant, 0);
        chk("t6_s_cycle_rst", s_cycle, 0);
        chk("t6_s_strobe_rst", s_strobe, 0);
        chk("t6_m1_ack_rst", m1_ack, 0);
        edge_(); resetn = 0; s_ack = 0; m0_cycle = 1; m0_strobe = 1; m0_addr = 15'h0041;
        edge_(); s_ack = 1; s_data_r = 16'h6161; push(0, 16'h6161);
        mid();
        chk("t6_m0_after_rst", grant, 1);
        chk("t6_s_addr", s_addr, 15'h0041);
        edge_(); s_ack = 0; m0_cycle = 0; m0_strobe = 0; m1_cycle = 0; m1_strobe = 0; m1_wr = 0;
        edge_(); edge_(); mid();
        chk("t6_final_idle", grant, 0);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter that shares the system data bus between the SPI slave bridge (master 0) and a second bus master (master 1, e.g. MCU or DMA port).
- Uses round-robin grant, holds the grant for a whole cycle, and has a per-transfer watchdog that stops a missing slave ack from hanging the SPI bridge.
- Sits between the master ports and the address decoder / slave mux.

Parameters:
ADDR_WIDTH, 15, address bus width.
DATA_WIDTH, 16, data bus width.
TIMEOUT, 255, cycles with strobe high and no ack before forced termination; 0 disables the watchdog.

Ports:
clk  input  1  system clock, rising edge.
resetn  input  1  synchronous reset, active-high despite the name.
m0_addr  input  ADDR_WIDTH  master 0 address.
m0_data_w  input  DATA_WIDTH  master 0 write data.
m0_wr  input  1  master 0 write enable.
m0_strobe  input  1  master 0 strobe.
m0_cycle  input  1  master 0 cycle request.
m0_ack  output  1  ack to master 0.
m0_data_r  output  DATA_WIDTH  read data to master 0.
m1_addr, m1_data_w, m1_wr, m1_strobe, m1_cycle, m1_ack, m1_data_r: same directions and widths as the m0 ports, for master 1.
s_addr  output  ADDR_WIDTH  slave-side address.
s_data_w  output  DATA_WIDTH  slave-side write data.
s_wr  output  1  slave-side write enable.
s_strobe  output  1  slave-side strobe.
s_cycle  output  1  slave-side cycle.
s_ack  input  1  slave ack.
s_data_r  input  DATA_WIDTH  slave read data.
grant  output  2  one-hot current owner: bit0 = m0, bit1 = m1, 00 = idle.
timeout_flag  output  1  sticky; set when the watchdog fires.
timeout_clr  input  1  clears timeout_flag.

Behaviour:
- State register: S_IDLE, S_GRANT0, S_GRANT1. Registers: last_grant (1 bit), wd_cnt (width clog2(TIMEOUT+1), minimum 1), timeout_flag.
- Reset (resetn=1 at a clk edge): state=S_IDLE, last_grant=1 so m0 wins the first contention, wd_cnt=0, timeout_flag=0.
  - With state S_IDLE, all s_* outputs, mX_ack and grant are 0.
  - Reset mid-transfer drops s_cycle/s_strobe the next cycle and issues no ack.
- S_IDLE:
  - m0_cycle only -> S_GRANT0; m1_cycle only -> S_GRANT1.
  - Both -> grant the master not equal to last_grant. last_grant updates on entry to the grant state.
  - Grant latency is 1 cycle: cycle asserted at edge N gives grant and s_strobe at N+1.
- S_GRANTx: combinational mux of mx_addr/data_w/wr/strobe/cycle onto s_*.
  - mx_ack = s_ack; the other master's ack = 0.
  - m0_data_r = m1_data_r = s_data_r; only ack qualifies the data.
- Release:
  - mx_cycle low at an edge -> S_IDLE, even without an ack.
  - There is always at least one S_IDLE cycle between grants, so no back-to-back ownership change.
  - The granted master keeps the bus while its cycle stays high, across multiple strobes.
- Watchdog (TIMEOUT>0):
  - wd_cnt increments each cycle in S_GRANTx with s_strobe=1 and s_ack=0.
  - It clears on s_ack, on strobe low, and in S_IDLE.
  - When wd_cnt==TIMEOUT-1 and there is still no ack:
    - that cycle: mx_ack=1, mx_data_r=0, s_strobe=s_cycle=0;
    - next edge: timeout_flag=1 and state -> S_IDLE.
  - A real s_ack in the same cycle as the firing has priority: normal ack, no flag.
- timeout_flag: set has priority over timeout_clr in the same cycle.
- Arbitration never preempts; a waiting master starves for at most one complete cycle of the other master plus 2 clocks.

Test Plan:
- Reset, then m0_cycle/strobe read addr 0x0010 with slave ack after 3 clocks, s_data_r=0xA5A5 -> grant=01 at N+1, s_addr=0x0010, m0_ack for 1 cycle with 0xA5A5, m1_ack stays 0, grant=00 one clock after m0_cycle drops.
- m0 and m1 request at the same edge, each doing one write and holding cycle until ack -> m0 served first, then m1 (grant 01, 00, 10); repeat both -> m1 served first.
- m1 holds cycle over 4 strobed writes (addr 0x20..0x23) while m0 requests -> m0 waits, granted only after m1_cycle falls; s_addr sequence 0x20..0x23 unbroken.
- TIMEOUT=8, slave never acks m0 -> after 8 strobe cycles m0_ack pulses once with data 0x0000, s_strobe drops, timeout_flag=1 persists until timeout_clr pulse.
- TIMEOUT=8, s_ack arrives on exactly the 8th stalled cycle -> normal ack with slave data, timeout_flag stays 0.
- resetn asserted while S_GRANT1 mid-write -> next cycle grant=00, s_cycle=0, no m1_ack; after reset deasserts, a contended request goes to m0.
